// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM loader: byte width constant and the
// loader state encoding.
//
// Contents:
//   ByteW   - width of one incoming byte (8)
//   state_e - loader FSM state type (StIdle, StCollect, StWrite, StDone)
package bram_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StWrite   = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/bram_loader.sv
// Byte-stream to BRAM loader. After a start pulse, collects bytes from a
// valid/ready stream, packs them little-endian into dataWidth_p-bit words
// and writes wordCount_p words to consecutive addresses starting at 0.
//
// Parameters:
//   memSize_p   - write-address width in bits
//   dataWidth_p - memory word width, multiple of 8 from 8 to 64
//   wordCount_p - words per load, 1 .. 2**memSize_p
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   start_i      - single-cycle pulse that begins a load (IDLE/DONE only)
//   byte_i       - incoming byte
//   byte_valid_i - byte_i valid this cycle
//   byte_ready_o - loader accepts a byte this cycle (COLLECT only)
//   we_o         - one-cycle memory write strobe
//   waddr_o      - memory write address
//   wdata_o      - memory write data
//   busy_o       - load in progress
//   done_o       - last load completed; held until next start or reset
//   checksum_o   - modulo-256 sum of bytes accepted since the last start
//
// Build option:
//   BRAM_LOADER_CHECKSUM_EN - when defined, checksum_o carries the running
//   byte sum; otherwise checksum_o is tied to zero and no checksum logic
//   exists.
module bram_loader
  import bram_pkg::*;
#(
  parameter int unsigned memSize_p   = 8,
  parameter int unsigned dataWidth_p = 16,
  parameter int unsigned wordCount_p = 2 ** memSize_p
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   we_o,
  output logic [memSize_p-1:0]   waddr_o,
  output logic [dataWidth_p-1:0] wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             checksum_o
);

  localparam int unsigned NumBytes = dataWidth_p / ByteW;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [IdxW-1:0]      LastIdx  = IdxW'(NumBytes - 1);
  localparam logic [memSize_p-1:0] LastAddr = memSize_p'(wordCount_p - 1);

  state_e                 state_q, state_d;
  logic [memSize_p-1:0]   addr_q;
  logic [IdxW-1:0]        byte_idx_q;
  logic [dataWidth_p-1:0] word_q;

  logic xfer;
  logic start_ok;
  logic last_byte;

  // start_i only has effect from IDLE or DONE; it is ignored mid-load.
  assign start_ok  = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign xfer      = byte_ready_o && byte_valid_i;
  assign last_byte = (byte_idx_q == LastIdx);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (xfer && last_byte) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Termination on the last word keeps the address from wrapping.
        state_d = (addr_q == LastAddr) ? StDone : StCollect;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from the registered state)
  // ---------------------------------------------------------------------
  always_comb begin
    byte_ready_o = 1'b0;
    we_o         = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle:    ;
      StCollect: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      StWrite: begin
        we_o   = 1'b1;
        busy_o = 1'b1;
      end
      StDone:    done_o = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: word address, byte index and inline little-endian packer.
  // Reset clears the partially assembled word so nothing stale survives.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else if (start_ok) begin
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      if (xfer) begin
        for (int unsigned k = 0; k < NumBytes; k++) begin
          if (byte_idx_q == IdxW'(k)) begin
            word_q[k*ByteW +: ByteW] <= byte_i;
          end
        end
        byte_idx_q <= last_byte ? '0 : byte_idx_q + 1'b1;
      end
      if ((state_q == StWrite) && (addr_q != LastAddr)) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Address and data are registered and do not change during WRITE.
  assign waddr_o = addr_q;
  assign wdata_o = word_q;

`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (xfer) begin
      checksum_q <= checksum_q + byte_i;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader (dataWidth_p=16, wordCount_p=4).
// Expected writes are derived from the list of bytes sent: word w at
// address w holds bytes 2w (low) and 2w+1 (high); the checksum is the
// byte sum modulo 256 (zero when BRAM_LOADER_CHECKSUM_EN is undefined).
module tb_bram_loader;

  localparam int unsigned MemSize   = 8;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned WordCount = 4;
  localparam int unsigned NumB      = DataWidth / 8;
  localparam int unsigned LoadBytes = WordCount * NumB;
`ifdef BRAM_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 we;
  logic [MemSize-1:0]   waddr;
  logic [DataWidth-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [7:0]           checksum;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_loader #(
    .memSize_p  (MemSize),
    .dataWidth_p(DataWidth),
    .wordCount_p(WordCount)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .byte_i      (byte_in),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum)
  );

  // Write / done-rise log, sampled on the falling edge.
  logic [MemSize-1:0]   wa_q[$];
  logic [DataWidth-1:0] wd_q[$];
  int                   wc_q[$];
  int                   dr_q[$];
  logic                 done_prev = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
    if (done && !done_prev) dr_q.push_back(cyc);
    done_prev <= done;
  end

  // ---------------- reference model ----------------
  function automatic logic [DataWidth-1:0] exp_word(input logic [7:0] b[$], input int w);
    logic [DataWidth-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NumB); k++) r[8*k +: 8] = b[w*NumB + k];
    return r;
  endfunction

  function automatic logic [7:0] exp_sum(input logic [7:0] b[$]);
    int s;
    s = 0;
    foreach (b[i]) s += int'(b[i]);
    return CkEn ? 8'(s % 256) : 8'h00;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dr_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] b[$]);
    b.delete();
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
  endtask

  // Presents bytes in order; gap_pct is the chance of an idle cycle.
  task automatic send_bytes(input logic [7:0] b[$], input int gap_pct, output bit timed_out);
    int i;
    int budget;
    i = 0; budget = 0; timed_out = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      budget++;
      if (budget > 2000) begin
        timed_out = 1'b1;
        break;
      end
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_in    = b[i];
        if (byte_ready) i++;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic wait_done(output bit timed_out);
    int n;
    n = 0; timed_out = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #2;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", byte_ready); else n_pass++;
    n_total++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else n_pass++;
    n_total++; if (waddr !== '0) $display("FAIL reset_waddr: got %h want 0", waddr); else n_pass++;
    n_total++; if (wdata !== '0) $display("FAIL reset_wdata: got %h want 0", wdata); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (checksum !== 8'h00) $display("FAIL reset_checksum: got %h want 00", checksum); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;  // no start yet: idle must not accept
    repeat (2) @(negedge clk);
    n_total++;
    if ({byte_ready, busy, done, we} !== 4'b0000)
      $display("FAIL idle_after_reset: got rdy/busy/done/we=%b want 0000", {byte_ready, busy, done, we});
    else n_pass++;
    byte_valid = 1'b0;
  endtask

  task automatic test_full_load();
    logic [7:0] b[$];
    bit to1, to2;
    do_reset();
    b.delete();
    for (int i = 1; i <= int'(LoadBytes); i++) b.push_back(8'(i));
    pulse_start();
    send_bytes(b, 0, to1);
    wait_done(to2);
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (to1 || to2) $display("FAIL full_timeout: got %b%b want 00", to1, to2); else n_pass++;
    n_total++; if (wa_q.size() != WordCount) $display("FAIL full_count: got %0d want %0d", wa_q.size(), WordCount); else n_pass++;
    for (int w = 0; w < int'(WordCount) && w < wa_q.size(); w++) begin
      n_total++;
      if (wa_q[w] !== MemSize'(w) || wd_q[w] !== exp_word(b, w))
        $display("FAIL full_write%0d: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp_word(b, w), MemSize'(w));
      else n_pass++;
    end
    n_total++;
    if (wc_q.size() == 0 || dr_q.size() == 0 || dr_q[$] != wc_q[$] + 1)
      $display("FAIL full_done_timing: got done@%0d want one cycle after last we",
               (dr_q.size() > 0) ? dr_q[$] : -1);
    else n_pass++;
    n_total++; if ({busy, done} !== 2'b01) $display("FAIL full_status: got busy/done=%b want 01", {busy, done}); else n_pass++;
    n_total++; if (checksum !== exp_sum(b)) $display("FAIL full_checksum: got %h want %h", checksum, exp_sum(b)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    int i, n, we_seen;
    do_reset();
    rand_bytes(LoadBytes, b);
    pulse_start();
    i = 0; n = 0; we_seen = 0;
    // Valid held high the whole time, including WRITE and DONE.
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (we) begin
        we_seen++;
        n_total++;
        if (byte_ready !== 1'b0) $display("FAIL bp_ready_in_write: got %b want 0", byte_ready); else n_pass++;
      end
      byte_valid = 1'b1;
      byte_in    = (i < int'(LoadBytes)) ? b[i] : 8'hEE;
      if (i < int'(LoadBytes) && byte_ready) i++;
    end
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    #1;
    n_total++; if (we_seen != int'(WordCount)) $display("FAIL bp_we_cycles: got %0d want %0d", we_seen, WordCount); else n_pass++;
    n_total++; if (wa_q.size() != WordCount) $display("FAIL bp_count: got %0d want %0d", wa_q.size(), WordCount); else n_pass++;
    for (int w = 0; w < int'(WordCount) && w < wa_q.size(); w++) begin
      n_total++;
      if (wa_q[w] !== MemSize'(w) || wd_q[w] !== exp_word(b, w))
        $display("FAIL bp_write%0d: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp_word(b, w), MemSize'(w));
      else n_pass++;
    end
    n_total++; if (checksum !== exp_sum(b)) $display("FAIL bp_checksum: got %h want %h", checksum, exp_sum(b)); else n_pass++;
  endtask

  task automatic test_gapped();
    logic [7:0] b[$];
    bit to1, to2;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      rand_bytes(LoadBytes, b);
      pulse_start();
      send_bytes(b, 40, to1);
      wait_done(to2);
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (to1 || to2) $display("FAIL gap_timeout%0d: got %b%b want 00", rep, to1, to2); else n_pass++;
      n_total++; if (wa_q.size() != WordCount) $display("FAIL gap_count%0d: got %0d want %0d", rep, wa_q.size(), WordCount); else n_pass++;
      for (int w = 0; w < int'(WordCount) && w < wa_q.size(); w++) begin
        n_total++;
        if (wa_q[w] !== MemSize'(w) || wd_q[w] !== exp_word(b, w))
          $display("FAIL gap_write%0d_%0d: got %h@%h want %h@%h", rep, w, wd_q[w], wa_q[w], exp_word(b, w), MemSize'(w));
        else n_pass++;
      end
      n_total++; if (checksum !== exp_sum(b)) $display("FAIL gap_checksum%0d: got %h want %h", rep, checksum, exp_sum(b)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b[$];
    bit to1;
    do_reset();
    rand_bytes(3, b);
    pulse_start();
    send_bytes(b, 0, to1);
    rst = 1'b1;
    #1;
    n_total++;
    if ({byte_ready, we, busy, done, checksum, waddr, wdata} !== '0)
      $display("FAIL midrst_outputs: got rdy=%b we=%b busy=%b done=%b ck=%h a=%h d=%h want all 0",
               byte_ready, we, busy, done, checksum, waddr, wdata);
    else n_pass++;
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    #1;
    n_total++; if (to1) $display("FAIL midrst_timeout: got 1 want 0"); else n_pass++;
    // Only the word completed by bytes 0 and 1 may have been written.
    n_total++; if (wa_q.size() != 1) $display("FAIL midrst_count: got %0d want 1", wa_q.size()); else n_pass++;
    if (wa_q.size() > 0) begin
      n_total++;
      if (wa_q[0] !== '0 || wd_q[0] !== exp_word(b, 0))
        $display("FAIL midrst_write0: got %h@%h want %h@00", wd_q[0], wa_q[0], exp_word(b, 0));
      else n_pass++;
    end
    n_total++; if ({busy, byte_ready, done} !== 3'b000) $display("FAIL midrst_idle: got busy/rdy/done=%b want 000", {busy, byte_ready, done}); else n_pass++;
  endtask

  task automatic test_restart();
    logic [7:0] b[$], first[$], rest[$], b2[$];
    bit to1, to2, to3, to4;
    do_reset();
    rand_bytes(LoadBytes, b);
    first.delete(); rest.delete();
    first.push_back(b[0]);
    for (int i = 1; i < int'(LoadBytes); i++) rest.push_back(b[i]);
    pulse_start();
    send_bytes(first, 0, to1);
    pulse_start();  // in COLLECT: must be ignored
    n_total++; if (busy !== 1'b1) $display("FAIL rs_busy_kept: got %b want 1", busy); else n_pass++;
    send_bytes(rest, 0, to2);
    wait_done(to3);
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (wa_q.size() != WordCount) $display("FAIL rs_count: got %0d want %0d", wa_q.size(), WordCount); else n_pass++;
    for (int w = 0; w < int'(WordCount) && w < wa_q.size(); w++) begin
      n_total++;
      if (wa_q[w] !== MemSize'(w) || wd_q[w] !== exp_word(b, w))
        $display("FAIL rs_write%0d: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp_word(b, w), MemSize'(w));
      else n_pass++;
    end
    n_total++; if (checksum !== exp_sum(b)) $display("FAIL rs_checksum: got %h want %h", checksum, exp_sum(b)); else n_pass++;
    // Restart from DONE.
    clear_log();
    pulse_start();
    n_total++;
    if ({done, busy, byte_ready, checksum} !== {3'b011, 8'h00})
      $display("FAIL rs_restart_state: got done/busy/rdy=%b ck=%h want 011 00", {done, busy, byte_ready}, checksum);
    else n_pass++;
    rand_bytes(LoadBytes, b2);
    send_bytes(b2, 20, to4);
    wait_done(to3);
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (to1 || to2 || to3 || to4) $display("FAIL rs_timeout: got %b%b%b%b want 0000", to1, to2, to3, to4); else n_pass++;
    n_total++; if (wa_q.size() != WordCount) $display("FAIL rs2_count: got %0d want %0d", wa_q.size(), WordCount); else n_pass++;
    for (int w = 0; w < int'(WordCount) && w < wa_q.size(); w++) begin
      n_total++;
      if (wa_q[w] !== MemSize'(w) || wd_q[w] !== exp_word(b2, w))
        $display("FAIL rs2_write%0d: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp_word(b2, w), MemSize'(w));
      else n_pass++;
    end
  endtask

  task automatic test_checksum();
    logic [7:0] b[$];
    bit to1;
    do_reset();
    b = '{8'hFF, 8'h02};
    pulse_start();
    send_bytes(b, 0, to1);
    #1;
    n_total++; if (to1) $display("FAIL ck_timeout: got 1 want 0"); else n_pass++;
    n_total++;
    if (checksum !== (CkEn ? 8'h01 : 8'h00))
      $display("FAIL ck_ff_02: got %h want %h", checksum, (CkEn ? 8'h01 : 8'h00));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_gapped();
    test_reset_mid_load();
    test_restart();
    test_checksum();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
